multicycle_control: RTL and testbench

- Multi-cycle MIPS control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives datapath enables per state.
- Stalls on a memory ready handshake, with a memory timeout, a retired-instruction counter and a halt state.
- Sits in CPU top between IR opcode field and the shared-memory multicycle datapath.

---
 rtl/mc_pkg.sv | 138 +++++++++++++
 rtl/multicycle_control_if.sv | 57 +++++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/multicycle_control.sv | 134 +++++++++++++
 tb/tb_multicycle_control.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, state
// encodings, datapath select codes and the per-state control decode.
package mc_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned ST_W       = 4;
  localparam int unsigned ALU_CODE_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_REXE   = 4'd3,
    ST_RWB    = 4'd4,
    ST_IEXE   = 4'd5,
    ST_IWB    = 4'd6,
    ST_MADDR  = 4'd7,
    ST_MREAD  = 4'd8,
    ST_MWB    = 4'd9,
    ST_MWRITE = 4'd10,
    ST_BEQ    = 4'd11,
    ST_JUMP   = 4'd12,
    ST_HALT   = 4'd13,
    ST_TRAP   = 4'd14
  } state_e;

  localparam logic [ALU_CODE_W-1:0] ALUOP_FUNCT = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALUOP_ADDI  = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALUOP_ADD   = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALUOP_SUB   = 3'b011;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic                  mem_req;
    logic                  mem_read;
    logic                  mem_write;
    logic                  iord;
    logic                  ir_write;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic [1:0]            pc_source;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CODE_W-1:0] alu_op;
    logic                  ext_op;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  mem_to_reg;
  } ctrl_t;

  // Moore control word for a state; ir_write/pc_write in FETCH are later
  // qualified by memory ready.
  function automatic ctrl_t decode_state(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = ALU_SRC_B_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PC_SRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_b = ALU_SRC_B_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
        c.ext_op    = 1'b1;
      end
      ST_REXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_SRC_B_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      ST_IEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_SRC_B_IMM;
        c.alu_op    = ALUOP_ADDI;
        c.ext_op    = 1'b1;
      end
      ST_IWB: c.reg_write = 1'b1;
      ST_MADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_SRC_B_IMM;
        c.alu_op    = ALUOP_ADD;
        c.ext_op    = 1'b1;
      end
      ST_MREAD: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = ALU_SRC_B_RT;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory signal bundle.
// Optional MC_ILLEGAL_TRAP_EN adds the sticky illegal_o flag.
interface multicycle_control_if #(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 32
);
  import mc_pkg::*;

  logic                start_i;
  logic [OP_W-1:0]     op_i;
  logic                mem_ready_i;
  logic                mem_req_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                iord_o;
  logic                ir_write_o;
  logic                pc_write_o;
  logic                pc_write_cond_o;
  logic [1:0]          pc_source_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [ALUOP_W-1:0]  alu_op_o;
  logic                ext_op_o;
  logic                reg_dst_o;
  logic                reg_write_o;
  logic                mem_to_reg_o;
  logic [CNT_W-1:0]    instr_cnt_o;
  logic                mem_err_o;
  logic [ST_W-1:0]     state_o;
`ifdef MC_ILLEGAL_TRAP_EN
  logic                illegal_o;
`endif

  // Control unit side
  modport master (
    input  start_i, op_i, mem_ready_i,
`ifdef MC_ILLEGAL_TRAP_EN
    output illegal_o,
`endif
    output mem_req_o, mem_read_o, mem_write_o, iord_o, ir_write_o,
           pc_write_o, pc_write_cond_o, pc_source_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, ext_op_o, reg_dst_o, reg_write_o,
           mem_to_reg_o, instr_cnt_o, mem_err_o, state_o
  );

  // Datapath / memory side
  modport slave (
    output start_i, op_i, mem_ready_i,
`ifdef MC_ILLEGAL_TRAP_EN
    input  illegal_o,
`endif
    input  mem_req_o, mem_read_o, mem_write_o, iord_o, ir_write_o,
           pc_write_o, pc_write_cond_o, pc_source_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, ext_op_o, reg_dst_o, reg_write_o,
           mem_to_reg_o, instr_cnt_o, mem_err_o, state_o
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts wait cycles of one memory access; expired_c flags the limit.
// MEM_TIMEOUT = 0 disables expiry.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired_c
);
  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] cnt_q;

  // Wait counter; holds at the limit so it never wraps.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  // Limit compare
  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign expired_c = 1'b0;
    end else begin : g_timeout
      assign expired_c = (cnt_q == TW'(MEM_TIMEOUT));
    end
  endgenerate
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// stalls on memory ready, halts on memory timeout, counts retirements.
// Optional MC_ILLEGAL_TRAP_EN: unsupported opcodes trap instead of NOP.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             retire_c;
  logic             expired_c;
  logic             timer_clr_c;

  assign timer_clr_c = (state_d != state_q) || bus.mem_ready_i;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr       (timer_clr_c),
    .en        (ctrl_q.mem_req),
    .expired_c (expired_c)
  );

  // Next-state and retire decision
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      ST_IDLE:   if (bus.start_i) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready_i)  state_d = ST_DECODE;
        else if (expired_c)   state_d = ST_HALT;
      end
      ST_DECODE: begin
        case (bus.op_i)
          OP_RTYPE:     state_d = ST_REXE;
          OP_ADDI:      state_d = ST_IEXE;
          OP_LW, OP_SW: state_d = ST_MADDR;
          OP_BEQ:       state_d = ST_BEQ;
          OP_J:         state_d = ST_JUMP;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = ST_TRAP;
`else
            state_d = ST_FETCH;
`endif
          end
        endcase
      end
      ST_REXE:   state_d = ST_RWB;
      ST_IEXE:   state_d = ST_IWB;
      ST_MADDR:  state_d = (bus.op_i == OP_LW) ? ST_MREAD : ST_MWRITE;
      ST_MREAD: begin
        if (bus.mem_ready_i)  state_d = ST_MWB;
        else if (expired_c)   state_d = ST_HALT;
      end
      ST_MWRITE: begin
        if (bus.mem_ready_i) begin
          state_d  = ST_FETCH;
          retire_c = 1'b1;
        end else if (expired_c) begin
          state_d  = ST_HALT;
        end
      end
      ST_RWB, ST_IWB, ST_MWB, ST_BEQ, ST_JUMP: begin
        state_d  = ST_FETCH;
        retire_c = 1'b1;
      end
      ST_HALT:   state_d = ST_HALT;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, registered control word, retire counter and sticky error
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d);
      if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
      if (state_d == ST_HALT) err_q <= 1'b1;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal-opcode flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_q <= 1'b0;
    end else if (state_d == ST_TRAP) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal_o = illegal_q;
`endif

  assign bus.mem_req_o       = ctrl_q.mem_req;
  assign bus.mem_read_o      = ctrl_q.mem_read;
  assign bus.mem_write_o     = ctrl_q.mem_write;
  assign bus.iord_o          = ctrl_q.iord;
  assign bus.ir_write_o      = ctrl_q.ir_write & bus.mem_ready_i;
  assign bus.pc_write_o      = ctrl_q.pc_write & (bus.mem_ready_i | ~ctrl_q.mem_req);
  assign bus.pc_write_cond_o = ctrl_q.pc_write_cond;
  assign bus.pc_source_o     = ctrl_q.pc_source;
  assign bus.alu_src_a_o     = ctrl_q.alu_src_a;
  assign bus.alu_src_b_o     = ctrl_q.alu_src_b;
  assign bus.alu_op_o        = ALUOP_W'(ctrl_q.alu_op);
  assign bus.ext_op_o        = ctrl_q.ext_op;
  assign bus.reg_dst_o       = ctrl_q.reg_dst;
  assign bus.reg_write_o     = ctrl_q.reg_write;
  assign bus.mem_to_reg_o    = ctrl_q.mem_to_reg;
  assign bus.instr_cnt_o     = cnt_q;
  assign bus.mem_err_o       = err_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (MEM_TIMEOUT = 4).
module tb_multicycle_control;

  localparam int unsigned TB_ALUOP_W = 3;
  localparam int unsigned TB_CNT_W   = 32;
  localparam int unsigned TB_TMO     = 4;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // One instruction: opcode, ready delays, expected state path (nibble 0 first)
  typedef struct {
    logic [5:0]  op;
    int          fdly;
    int          mdly;
    int          n;
    logic [23:0] path;
    bit          retire;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  multicycle_control_if #(.ALUOP_W(TB_ALUOP_W), .CNT_W(TB_CNT_W)) bus ();

  multicycle_control #(
    .ALUOP_W     (TB_ALUOP_W),
    .MEM_TIMEOUT (TB_TMO),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] cnt_model = '0;
  logic [18:0] exp_ctrl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [18:0] obs();
    return {bus.mem_req_o, bus.mem_read_o, bus.mem_write_o, bus.iord_o,
            bus.ir_write_o, bus.pc_write_o, bus.pc_write_cond_o, bus.pc_source_o,
            bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.ext_op_o,
            bus.reg_dst_o, bus.reg_write_o, bus.mem_to_reg_o};
  endfunction

  // Expected instruction path from the ISA rules
  function automatic vec_t model(input logic [5:0] op, input int fd, input int md);
    vec_t v;
    v.op = op; v.fdly = fd; v.mdly = md; v.retire = 1'b1;
    case (op)
      6'b000000: begin v.n = 4; v.path = 24'h004321; end
      6'b001000: begin v.n = 4; v.path = 24'h006521; end
      6'b100011: begin v.n = 5; v.path = 24'h098721; end
      6'b101011: begin v.n = 4; v.path = 24'h00A721; end
      6'b000100: begin v.n = 3; v.path = 24'h000B21; end
      6'b000010: begin v.n = 3; v.path = 24'h000C21; end
      default:   begin v.n = 2; v.path = 24'h000021; v.retire = 1'b0; end
    endcase
    return v;
  endfunction

  task automatic check_state(input string tag, input logic [3:0] s, input logic rdy);
    logic [18:0] want;
    want = exp_ctrl[s];
    if (want[18] && !rdy) want = want & ~19'h06000;
    chk({tag, " state"}, 64'(bus.state_o), 64'(s));
    chk({tag, " ctrl"}, 64'(obs()), 64'(want));
    chk({tag, " mem_err"}, 64'(bus.mem_err_o), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " state"}, 64'(bus.state_o), 64'd0);
    chk({tag, " ctrl"}, 64'(obs()), 64'd0);
    chk({tag, " instr_cnt"}, 64'(bus.instr_cnt_o), 64'd0);
    chk({tag, " mem_err"}, 64'(bus.mem_err_o), 64'd0);
`ifdef MC_ILLEGAL_TRAP_EN
    chk({tag, " illegal"}, 64'(bus.illegal_o), 64'd0);
`endif
  endtask

  // Assert reset mid-cycle, check, then release with start held
  task automatic reset_restart(input string tag);
    rst_i = 1'b0;
    #1;
    check_reset(tag);
    cnt_model = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.start_i = 1'b1;
  endtask

  task automatic run_instr(input vec_t v);
    int         d;
    logic [3:0] s;
    bit         is_mem;
    for (int i = 0; i < v.n; i++) begin
      s = v.path[4*i +: 4];
      is_mem = (s == 4'd1) || (s == 4'd8) || (s == 4'd10);
      d = (s == 4'd1) ? v.fdly : (is_mem ? v.mdly : 0);
      for (int k = 0; k <= d; k++) begin
        @(negedge clk_i);
        bus.op_i = v.op;
        bus.start_i = 1'($urandom_range(0, 1));
        bus.mem_ready_i = is_mem ? (k == d) : 1'($urandom_range(0, 1));
        #1;
        check_state($sformatf("op%h s%0d", v.op, s), s, bus.mem_ready_i);
        if (i == 0 && k == 0) chk("instr_cnt", 64'(bus.instr_cnt_o), 64'(cnt_model));
      end
    end
    if (v.retire) cnt_model = cnt_model + 32'd1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [8];
    vec_t       v;
    logic [5:0] sup [6];
    logic [5:0] op;

    bus.start_i = 1'b0;
    bus.op_i = '0;
    bus.mem_ready_i = 1'b0;

    // {mem_req,mem_read,mem_write,iord,ir_wr,pc_wr,pc_wr_cond,pc_src,src_a,src_b,alu_op,ext,reg_dst,reg_wr,mem2reg}
    for (int i = 0; i < 16; i++) exp_ctrl[i] = '0;
    exp_ctrl[1]  = {4'b1100, 3'b110, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
    exp_ctrl[2]  = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b1000};
    exp_ctrl[3]  = {4'b0000, 3'b000, 2'b00, 1'b1, 2'b00, 3'b000, 4'b0000};
    exp_ctrl[4]  = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0110};
    exp_ctrl[5]  = {4'b0000, 3'b000, 2'b00, 1'b1, 2'b10, 3'b001, 4'b1000};
    exp_ctrl[6]  = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0010};
    exp_ctrl[7]  = {4'b0000, 3'b000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b1000};
    exp_ctrl[8]  = {4'b1101, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
    exp_ctrl[9]  = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0011};
    exp_ctrl[10] = {4'b1011, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
    exp_ctrl[11] = {4'b0000, 3'b001, 2'b01, 1'b1, 2'b00, 3'b011, 4'b0000};
    exp_ctrl[12] = {4'b0000, 3'b010, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0000};

    tbl[0] = '{op: 6'b000000, fdly: 0, mdly: 0, n: 4, path: 24'h004321, retire: 1'b1};
    tbl[1] = '{op: 6'b100011, fdly: 0, mdly: 3, n: 5, path: 24'h098721, retire: 1'b1};
    tbl[2] = '{op: 6'b101011, fdly: 1, mdly: 2, n: 4, path: 24'h00A721, retire: 1'b1};
    tbl[3] = '{op: 6'b000100, fdly: 0, mdly: 0, n: 3, path: 24'h000B21, retire: 1'b1};
    tbl[4] = '{op: 6'b000010, fdly: 2, mdly: 0, n: 3, path: 24'h000C21, retire: 1'b1};
    tbl[5] = '{op: 6'b001000, fdly: 4, mdly: 0, n: 4, path: 24'h006521, retire: 1'b1};
    tbl[6] = '{op: 6'b100011, fdly: 4, mdly: 4, n: 5, path: 24'h098721, retire: 1'b1};
    tbl[7] = '{op: 6'b111111, fdly: 0, mdly: 0, n: 2, path: 24'h000021, retire: 1'b0};

    sup[0] = 6'b000000; sup[1] = 6'b001000; sup[2] = 6'b100011;
    sup[3] = 6'b101011; sup[4] = 6'b000100; sup[5] = 6'b000010;

    // Reset state, then IDLE waits for start
    rst_i = 1'b0;
    #2;
    check_reset("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_state("idle_no_start", 4'd0, 1'b0);
    @(negedge clk_i);
    #1;
    check_state("idle_hold", 4'd0, 1'b0);
    bus.start_i = 1'b1;

    // Directed instruction table
    for (int i = 0; i < 8; i++) begin
      if (!(TRAP_EN && !tbl[i].retire)) run_instr(tbl[i]);
    end

    // Memory timeout in FETCH: four wait cycles, limit cycle, then HALT
    for (int k = 0; k <= int'(TB_TMO); k++) begin
      @(negedge clk_i);
      bus.mem_ready_i = 1'b0;
      bus.start_i = 1'b0;
      #1;
      check_state("tmo_fetch", 4'd1, 1'b0);
      if (k == 0) chk("tmo_cnt", 64'(bus.instr_cnt_o), 64'(cnt_model));
    end
    @(negedge clk_i);
    #1;
    chk("halt state", 64'(bus.state_o), 64'd13);
    chk("halt mem_err", 64'(bus.mem_err_o), 64'd1);
    chk("halt ctrl", 64'(obs()), 64'd0);
    @(negedge clk_i);
    bus.mem_ready_i = 1'b1;
    bus.start_i = 1'b1;
    #1;
    chk("halt sticky state", 64'(bus.state_o), 64'd13);
    chk("halt sticky err", 64'(bus.mem_err_o), 64'd1);
    chk("halt cnt", 64'(bus.instr_cnt_o), 64'(cnt_model));
    reset_restart("rst_after_halt");

    // Reset asserted in the middle of an MREAD stall
    run_instr(model(6'b000000, 0, 0));
    begin
      logic [3:0] pre [3];
      pre[0] = 4'd1; pre[1] = 4'd2; pre[2] = 4'd7;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk_i);
        bus.op_i = 6'b100011;
        bus.mem_ready_i = 1'b1;
        #1;
        check_state("mrst_pre", pre[i], 1'b1);
      end
    end
    @(negedge clk_i);
    bus.mem_ready_i = 1'b0;
    #1;
    check_state("mrst_mread", 4'd8, 1'b0);
    chk("mrst cnt_before", 64'(bus.instr_cnt_o), 64'd1);
    #1;
    reset_restart("rst_mid_mread");

`ifdef MC_ILLEGAL_TRAP_EN
    // Unsupported opcode traps and sets the sticky flag
    @(negedge clk_i);
    bus.op_i = 6'b111111;
    bus.mem_ready_i = 1'b1;
    #1;
    check_state("trap_fetch", 4'd1, 1'b1);
    @(negedge clk_i);
    #1;
    check_state("trap_decode", 4'd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      #1;
      chk("trap state", 64'(bus.state_o), 64'd14);
      chk("trap illegal", 64'(bus.illegal_o), 64'd1);
      chk("trap ctrl", 64'(obs()), 64'd0);
      chk("trap cnt", 64'(bus.instr_cnt_o), 64'd0);
    end
    reset_restart("rst_after_trap");
`endif

    // Random instruction stream against the path model
    for (int i = 0; i < 60; i++) begin
      if (TRAP_EN || $urandom_range(0, 1) == 1) op = sup[$urandom_range(0, 5)];
      else op = 6'($urandom_range(0, 63));
      v = model(op, int'($urandom_range(0, TB_TMO)), int'($urandom_range(0, TB_TMO)));
      run_instr(v);
    end
    @(negedge clk_i);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("final state", 64'(bus.state_o), 64'd1);
    chk("final cnt", 64'(bus.instr_cnt_o), 64'(cnt_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
